// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP datapath stream blocks.
// Optional build macro AXIS_PKT_FIFO_ERR_DROP_EN is consumed by axis_pkt_fifo.
package udp_pkg;

    localparam int DATA_W = 256;
    localparam int KEEP_W = DATA_W / 8;
    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } axis_beat_t;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } fifo_state_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(
        input logic [DROP_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat bundle with valid/ready handshake.
// Master drives the beat, slave drives tready.
interface axis_pkt_fifo_if #(
    parameter int DATA_W = 256
) ();

    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port beat store: registered write, combinational read.
// Contents are not reset; the read side gates data with valid.
module fifo_ram #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream packet FIFO, cut-through or store-and-forward.
// Macro AXIS_PKT_FIFO_ERR_DROP_EN: discard frames whose tlast beat has tuser=1.
module axis_pkt_fifo
    import udp_pkg::*;
#(
    parameter int DATA_W       = 256,
    parameter int DEPTH_LOG2   = 4,
    parameter int STORE_FWD    = 1,
    parameter int AFULL_THRESH = 2**DEPTH_LOG2 - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_pkt_fifo_if.slave        s_axis,
    axis_pkt_fifo_if.master       m_axis,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   pkt_count,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int DEPTH  = 2**DEPTH_LOG2;
    localparam int PW     = DEPTH_LOG2 + 1;
    localparam int MW     = DATA_W + KEEP_W + 1;

    fifo_state_e           st_q, st_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         cm_q, cm_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [PW-1:0]         pkt_q, pkt_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  rdy_q;

    logic          full;
    logic          dropping;
    logic          s_rdy;
    logic          wr_fire;
    logic          m_vld;
    logic          rd_fire;
    logic          rd_last;
    logic          err_last;
    logic          mem_we;
    logic          pkt_inc;
    logic          pkt_dec;
    logic [MW-1:0] mem_rdata;

    assign fill_level = wr_q - rd_q;
    assign full       = (fill_level == PW'(DEPTH));
    assign dropping   = (st_q == ST_DROP);
    assign s_rdy      = rdy_q && (!full || dropping);
    assign wr_fire    = s_axis.tvalid && s_rdy;
    assign m_vld      = (cm_q != rd_q);
    assign rd_fire    = m_vld && m_axis.tready;
    assign rd_last    = mem_rdata[0];

`ifdef AXIS_PKT_FIFO_ERR_DROP_EN
    assign err_last = (STORE_FWD != 0) && s_axis.tuser;
`else
    logic unused_tuser;
    assign unused_tuser = s_axis.tuser;
    assign err_last     = 1'b0;
`endif

    always_comb begin
        st_d    = st_q;
        wr_d    = wr_q;
        cm_d    = cm_q;
        rd_d    = rd_q;
        drop_d  = drop_q;
        mem_we  = 1'b0;
        pkt_inc = 1'b0;
        if (rd_fire) begin
            rd_d = rd_q + 1'b1;
        end
        unique case (st_q)
            ST_ACCEPT: begin
                // Full with nothing committed: the frame can never fit.
                if ((STORE_FWD != 0) && full && (cm_q == rd_q)) begin
                    wr_d   = cm_q;
                    st_d   = ST_DROP;
                    drop_d = sat_inc(drop_q);
                end else if (wr_fire) begin
                    if (s_axis.tlast && err_last) begin
                        wr_d   = cm_q;
                        drop_d = sat_inc(drop_q);
                    end else begin
                        mem_we = 1'b1;
                        wr_d   = wr_q + 1'b1;
                        if (STORE_FWD == 0) begin
                            cm_d    = wr_q + 1'b1;
                            pkt_inc = s_axis.tlast;
                        end else if (s_axis.tlast) begin
                            cm_d    = wr_q + 1'b1;
                            pkt_inc = 1'b1;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (wr_fire && s_axis.tlast) begin
                    st_d = ST_ACCEPT;
                end
            end
            default: st_d = ST_ACCEPT;
        endcase
        pkt_dec = rd_fire && rd_last;
        pkt_d   = pkt_q + PW'(pkt_inc) - PW'(pkt_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_ACCEPT;
            wr_q   <= '0;
            cm_q   <= '0;
            rd_q   <= '0;
            pkt_q  <= '0;
            drop_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            wr_q   <= wr_d;
            cm_q   <= cm_d;
            rd_q   <= rd_d;
            pkt_q  <= pkt_d;
            drop_q <= drop_d;
            rdy_q  <= 1'b1;
        end
    end

    fifo_ram #(
        .W  (MW),
        .AW (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_q[DEPTH_LOG2-1:0]),
        .wdata_i ({s_axis.tdata, s_axis.tkeep, s_axis.tlast}),
        .raddr_i (rd_q[DEPTH_LOG2-1:0]),
        .rdata_o (mem_rdata)
    );

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = m_vld;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast} =
        m_vld ? mem_rdata : '0;
    assign m_axis.tuser  = 1'b0;

    assign almost_full = (fill_level >= PW'(AFULL_THRESH));
    assign pkt_count   = pkt_q;
    assign drop_count  = drop_q;

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
Second-generation single-clock stream FIFO for the UDP datapath, with full AXI-Stream valid/ready on both sides. Data, keep and last are stored per beat, and keep width is derived from data width. An elaboration-time mode selects cut-through or store-and-forward. Store-and-forward holds whole frames until their last beat, so that downstream header parsers never stall mid-packet. Status outputs are provided for flow control and for the statistics block.

Parameters:
DATA_W, 256, tdata width in bits; must be a multiple of 8.
KEEP_W, DATA_W/8, tkeep width (localparam, derived).
DEPTH_LOG2, 4, storage depth = 2^DEPTH_LOG2 beats.
STORE_FWD, 1, 1 = store-and-forward, 0 = cut-through.
AFULL_THRESH, 2^DEPTH_LOG2-2, almost_full asserts when fill_level >= this value.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  write beat valid
s_axis_tready  out  1  FIFO can accept a beat
s_axis_tdata  in  DATA_W  write data
s_axis_tkeep  in  KEEP_W  byte enables
s_axis_tlast  in  1  end of frame
s_axis_tuser  in  1  frame error flag, sampled on the tlast beat
m_axis_tvalid  out  1  read beat valid
m_axis_tready  in  1  downstream accepts
m_axis_tdata  out  DATA_W  read data
m_axis_tkeep  out  KEEP_W  read keep
m_axis_tlast  out  1  read last
fill_level  out  DEPTH_LOG2+1  beats written and not yet read (wr_ptr - rd_ptr)
almost_full  out  1  fill_level >= AFULL_THRESH
pkt_count  out  DEPTH_LOG2+1  committed frames not yet fully read
drop_count  out  16  frames discarded; saturates at 0xFFFF

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All pointers, counters and the drop state are cleared.
- Outputs during reset: m_axis_tvalid=0, s_axis_tready=0, fill_level=0, pkt_count=0, drop_count=0, almost_full=0, m_axis_* data fields=0.
- Outputs after reset: s_axis_tready=1 from the first clock edge after reset release.
- Reset mid-frame: any partial frame is lost and not counted as a drop.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each DEPTH_LOG2+1 bits. Wrap is natural modulo 2^(DEPTH_LOG2+1); memory is indexed by the low DEPTH_LOG2 bits.
- Full and write acceptance:
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - s_axis_tready = !full || dropping.
  - A write occurs on s_axis_tvalid && s_axis_tready.
- Commit:
  - Cut-through: commit_ptr follows wr_ptr every beat.
  - Store-and-forward: commit_ptr <= wr_ptr+1 on an accepted tlast beat that is not being dropped.
  - pkt_count increments on each commit of a tlast beat.
- Read path (first-word fall-through, combinational from memory):
  - m_axis_tvalid = (commit_ptr != rd_ptr).
  - When m_axis_tvalid=0, the data fields are driven to 0.
  - A read occurs on m_axis_tvalid && m_axis_tready; rd_ptr increments.
  - pkt_count decrements on a read of a tlast beat.
- Latency: 1 cycle from an accepted write to m_axis_tvalid in cut-through. In store-and-forward, 1 cycle after the tlast beat is accepted.
- Simultaneous read and write: both are permitted in the same cycle, including when full. A write is accepted only if full was 0 at the start of the cycle, so there is no read-to-write bypass.
- Simultaneous commit and read of a tlast beat: pkt_count is unchanged.
- Oversize frame (store-and-forward only):
  - Trigger: full && commit_ptr == rd_ptr, i.e. the frame cannot fit.
  - Action: wr_ptr <= commit_ptr, enter DROP state, drop_count++.
- State machine: IDLE/ACCEPT and DROP.
  - In DROP, s_axis_tready=1 and beats are discarded.
  - DROP returns to ACCEPT on the accepted tlast beat.
  - A single-beat tlast arriving while already in DROP ends the drop; it is not written.
- Error drop: controlled by the optional feature below; otherwise s_axis_tuser is ignored.

Optional Feature:
Macro: AXIS_PKT_FIFO_ERR_DROP_EN. Applies only when STORE_FWD=1.
- Defined: an accepted tlast beat with s_axis_tuser=1 does not commit. Instead:
  - wr_ptr <= commit_ptr, rewinding the whole frame.
  - drop_count increments, saturating.
  - The frame is never visible on m_axis.
- Not defined: s_axis_tuser is unused; the port remains for interface stability. Lint waiver is allowed.

Decomposition:
- Shared package udp_pkg holds:
  - Typedef axis_beat_t {data, keep, last}, parameterised via DATA_W in the package.
  - Constant DROP_CNT_W=16.
  - Enum fifo_state_e {ST_ACCEPT, ST_DROP}.
- Sub-module fifo_ram: simple dual-port memory with registered write and combinational read, DEPTH x (DATA_W+KEEP_W+1). Instantiated once.

Test Plan:
- Cut-through, 3-beat frame, m_axis_tready=1:
  - Beats appear 1 cycle after each write.
  - tkeep on the last beat = 0x0000FFFF is preserved.
  - fill_level returns to 0.
- Store-and-forward, 4-beat frame:
  - m_axis_tvalid stays 0 until the cycle after tlast is accepted.
  - Then pkt_count=1, then the 4 beats are read back.
  - pkt_count returns to 0.
- Fill DEPTH=16 beats with m_axis_tready=0:
  - s_axis_tready drops after beat 16.
  - Then assert both valid and ready for 20 cycles: throughput is 1 beat/cycle and there is no loss or duplication.
- Store-and-forward, 20-beat frame into a 16-deep FIFO:
  - drop_count=1.
  - FIFO stays empty; the remaining beats are absorbed.
  - A following 2-beat frame is delivered intact.
- With AXIS_PKT_FIFO_ERR_DROP_EN, frames A (3 beats), B (tuser=1) and C:
  - Only A and C are output.
  - drop_count=1; pkt_count peaks at 2.
- Assert rst_n mid-frame after 2 beats:
  - All outputs go to their reset values immediately.
  - After release, a new frame passes normally.
